// File: rtl/cab_led_sequencer_if.sv
// CPU write port and cabinet LED pin bundle for the LED sequencer.
// The slave side accepts writes and drives the board bus; the master side is the CPU/decode view.
interface cab_led_sequencer_if;
    logic       WR_EN;
    logic [1:0] WR_SEL;
    logic [7:0] WR_DATA;
    logic [7:0] LED_DATA;
    logic [2:0] LED_LATCH;
    logic       BUSY;
    logic       OVERWRITE;

    modport master (
        output WR_EN, WR_SEL, WR_DATA,
        input  LED_DATA, LED_LATCH, BUSY, OVERWRITE
    );

    modport slave (
        input  WR_EN, WR_SEL, WR_DATA,
        output LED_DATA, LED_LATCH, BUSY, OVERWRITE
    );
endinterface

// File: rtl/cab_led_sequencer.sv
// Serialises marquee/LED1/LED2 byte writes onto the shared LED bus with setup/strobe/hold timing.
// Selection one cycle after a write when idle; writes always accepted (one pending byte per target).
module cab_led_sequencer #(
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 8,
    parameter int HOLD_CYC  = 4
) (
    input logic              CLK_24M,
    input logic              nRESET,
    cab_led_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
    localparam logic [15:0] PULSE_LD = 16'(PULSE_CYC - 1);
    localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  ptr;
    logic [1:0]  sel;
    logic [2:0]  pend;
    logic [7:0]  data [3];
    logic [7:0]  led_data;
    logic [2:0]  led_latch;
    logic        overwrite;

    logic [1:0]  c1, c2, c3;
    logic [1:0]  pick_ch;
    logic        pick_vld;
    logic        sel_now;
    logic [2:0]  sel_oh;
    logic [2:0]  wr_oh;
    logic [2:0]  pend_nx;
    logic [7:0]  pick_dat;

    function automatic logic [1:0] nxt(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    // Round-robin: the channel after the last one served gets first look.
    always_comb begin
        c1       = nxt(ptr);
        c2       = nxt(c1);
        c3       = nxt(c2);
        pick_vld = 1'b1;
        pick_ch  = c1;
        if (pend[c1])      pick_ch = c1;
        else if (pend[c2]) pick_ch = c2;
        else if (pend[c3]) pick_ch = c3;
        else               pick_vld = 1'b0;
    end

    always_comb begin
        sel_now  = (state == IDLE) && pick_vld;
        sel_oh   = sel_now ? (3'b001 << pick_ch) : 3'b000;
        // WR_SEL=3 shifts the bit out of the vector, so it touches nothing.
        wr_oh    = bus.WR_EN ? (3'b001 << bus.WR_SEL) : 3'b000;
        pend_nx  = (pend & ~sel_oh) | wr_oh;
        pick_dat = data[pick_ch] & ((pick_ch == 2'd0) ? 8'h3F : 8'hFF);
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= 2'd2;
            sel       <= 2'd0;
            pend      <= 3'b000;
            for (int i = 0; i < 3; i++) data[i] <= 8'h00;
            led_data  <= 8'h00;
            led_latch <= 3'b000;
            overwrite <= 1'b0;
        end else begin
            pend <= pend_nx;
            // A write landing on the channel being selected is a fresh byte, not a replacement.
            overwrite <= |(wr_oh & pend & ~sel_oh);
            for (int i = 0; i < 3; i++) begin
                if (wr_oh[i]) data[i] <= bus.WR_DATA;
            end

            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        led_data <= pick_dat;
                        sel      <= pick_ch;
                        ptr      <= pick_ch;
                        cnt      <= SETUP_LD;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 16'd0) begin
                        led_latch <= 3'b001 << sel;
                        cnt       <= PULSE_LD;
                        state     <= PULSE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                PULSE: begin
                    if (cnt == 16'd0) begin
                        led_latch <= 3'b000;
                        cnt       <= HOLD_LD;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 16'd0) state <= IDLE;
                    else              cnt   <= cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.LED_DATA  = led_data;
    assign bus.LED_LATCH = led_latch;
    assign bus.OVERWRITE = overwrite;
    assign bus.BUSY      = (state != IDLE) | (|pend);
endmodule

// File: doc/cab_led_sequencer.md
Name: cab_led_sequencer

Overview:
Serialises CPU writes to the cabinet marquee (MV-ELA) and the two LED display boards (MV-LED) onto the shared LED_DATA bus and its three latch strobes. Accepts single-cycle write requests, holds one pending byte per target, and arbitrates round-robin among the targets. Each transfer is a timed setup/strobe/hold sequence; the boards capture data on the falling edge of their LED_LATCH bit. Sits between the system I/O register decode and the cabinet I/O pins.

Parameters:
SETUP_CYC, 4, cycles LED_DATA is stable before the strobe rises (min 1)
PULSE_CYC, 8, cycles the selected LED_LATCH bit stays high (min 1)
HOLD_CYC, 4, cycles LED_DATA is held after the strobe falls (min 1)

Ports:
CLK_24M  in  1  system clock, rising edge
nRESET  in  1  asynchronous active-low reset
WR_EN  in  1  single-cycle write strobe
WR_SEL  in  2  target: 0 marquee, 1 LED1, 2 LED2, 3 ignored
WR_DATA  in  8  byte to deliver
LED_DATA  out  8  shared data bus to the boards
LED_LATCH  out  3  per-target strobe, idle low; boards latch on the falling edge
BUSY  out  1  high when any pending bit is set or the FSM is not IDLE
OVERWRITE  out  1  one-cycle pulse when a write replaces an undelivered pending byte

Behaviour:
- Reset (asynchronous, immediate) sets: LED_DATA=0, LED_LATCH=000, BUSY=0, OVERWRITE=0, all pending bits cleared, FSM=IDLE, round-robin pointer=2 (so channel 0 has first priority).
- Reset asserted during PULSE drops the strobe immediately. The resulting falling edge is permitted; the board content after such a reset is undefined.
- Pending store: each channel has pend[ch] and data[ch].
  - WR_EN with WR_SEL<3 sets pend and loads data on the same edge.
  - If pend was already set, the byte is replaced and OVERWRITE pulses on the next cycle.
  - WR_SEL=3 is ignored entirely: no state change, no OVERWRITE.
- Marquee: LED_DATA[7:6] is forced to 0 when channel 0 is transferred.
- FSM states IDLE, SETUP, PULSE, HOLD, with a down-counter reloaded on each state entry.
- IDLE: if any pend bit is set, select the first pending channel after the pointer (order 0→1→2→0). On that edge:
  - LED_DATA ← data[sel]; pend[sel] cleared; pointer ← sel; go to SETUP.
  - LED_LATCH stays 000.
  - If no pend bit is set, stay in IDLE and hold LED_DATA.
- Write colliding with selection: a write to channel sel on the selection edge wins. The old byte is transferred, pend[sel] stays set with the new byte, and no OVERWRITE pulse is generated.
- SETUP: lasts SETUP_CYC cycles, then go to PULSE.
- PULSE: LED_LATCH[sel]=1 for exactly PULSE_CYC cycles; the other two bits stay 0.
- HOLD: LED_LATCH=000 and LED_DATA unchanged for HOLD_CYC cycles, then return to IDLE.
  - IDLE occupies at least 1 cycle between transfers.
  - LED_DATA keeps the last value until the next selection.
- Latency: write at edge N → selection at edge N+1 (if IDLE) → strobe rises at edge N+1+SETUP_CYC → strobe falls at N+1+SETUP_CYC+PULSE_CYC. One transfer takes SETUP+PULSE+HOLD+1 cycles.
- Only one LED_LATCH bit is ever high at a time.
- LED_DATA never changes while any strobe is high, nor within HOLD_CYC cycles after a strobe falls.
- Writes are accepted in every state; the block never back-pressures.
- BUSY = (state≠IDLE) | (|pend). Computed combinationally from registers, with no input-to-output combinational path.

Test Plan:
- Reset → LED_LATCH=000, LED_DATA=00, BUSY=0. Write sel=1 data=A5 at edge 10 → LED_DATA=A5 from edge 11; LED_LATCH=010 over edges 15..22 (defaults); BUSY low after edge 27.
- Same-cycle-apart writes sel0=FF, sel1=12, sel2=34 while IDLE → strobes in order 001, 010, 100. Marquee transfer shows LED_DATA=3F; each transfer spans 17 cycles.
- Two writes to sel2 (11 then 22) before its selection → single transfer of 22, one OVERWRITE pulse.
- Write sel0=55 during the sel0 PULSE of 44 → 44 strobe completes unchanged, followed by a second transfer of 55; no OVERWRITE.
- Write sel=3 data=99 → no strobe, BUSY stays 0, OVERWRITE stays 0.
- nRESET low mid-PULSE → LED_LATCH=000 and LED_DATA=00 asynchronously, all pending cleared. After release, a new write sel1 is delivered normally.
